// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-controller bus: program-load port, instruction-memory port and decode handshake.
// master = fetch controller side, slave = memory/decode/loader side.
interface instr_fetch_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          start;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    modport master (
        input  start, load_en, load_addr, load_data, mem_rdata,
               instr_ready, redirect, redirect_pc,
        output load_ack, mem_addr, mem_we, mem_wdata, instr, instr_valid,
               pc, busy, halted
    );

    modport slave (
        output start, load_en, load_addr, load_data, mem_rdata,
               instr_ready, redirect, redirect_pc,
        input  load_ack, mem_addr, mem_we, mem_wdata, instr, instr_valid,
               pc, busy, halted
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: PC, memory-port arbitration (fetch vs program load), decode handshake.
// Optional FETCH_COUNT_EN adds a saturating 16-bit handshake counter on instr_count.
module instr_fetch_ctrl #(
    parameter int            AW       = 8,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [3:0]    HALT_OPC = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_ctrl_if.master   bus
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]          instr_count
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] instr_q;
    logic          valid_q;
    logic          busy_q;
    logic          halted_q;

    logic load_ack;
    logic start_ok;
    logic handshake;
    logic advance;
    logic is_halt;

    // Loads own the memory port whenever fetch is not running; a load also masks start.
    always_comb begin
        load_ack  = bus.load_en && (state_q != RUN);
        start_ok  = bus.start && !bus.load_en && (state_q != RUN);
        handshake = valid_q && bus.instr_ready;
        advance   = (state_q == RUN) && (!valid_q || bus.instr_ready);
        is_halt   = (bus.mem_rdata[DW-1 -: 4] == HALT_OPC);
    end

    assign bus.load_ack    = load_ack;
    assign bus.mem_we      = load_ack;
    assign bus.mem_addr    = load_ack ? bus.load_addr : pc_q;
    assign bus.mem_wdata   = bus.load_data;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (start_ok) begin
                        state_q  <= RUN;
                        pc_q     <= RESET_PC;
                        valid_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end else if (handshake) begin
                        valid_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.redirect) begin
                        pc_q    <= bus.redirect_pc;
                        valid_q <= 1'b0;
                    end else if (advance) begin
                        if (is_halt) begin
                            // Halt word is never issued; an unconsumed word stays for decode.
                            state_q  <= HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                            if (handshake) valid_q <= 1'b0;
                        end else begin
                            instr_q <= bus.mem_rdata;
                            valid_q <= 1'b1;
                            pc_q    <= pc_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_ok)
            cnt_d = '0;
        else if (handshake && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed and randomized bench for instr_fetch_ctrl with a behavioural memory and
// an expected-stream reference built from the loaded program image.
module tb_instr_fetch_ctrl;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

`ifdef FETCH_COUNT_EN
    logic [15:0] instr_count;
`endif

    instr_fetch_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    // Single-port memory: combinational read, write on rising edge.
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d, input bit with_start);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        bus.start     = with_start;
        #1;
        if (with_start) begin
            chk("load_ack_idle", {31'd0, bus.load_ack}, 32'd1);
            chk("mem_we_load", {31'd0, bus.mem_we}, 32'd1);
            chk("mem_addr_load", {24'd0, bus.mem_addr}, {24'd0, a});
        end
        tick();
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        ref_mem[a]  = d;
        if (with_start) chk("load_start_not_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_to_halt();
        for (int i = 0; i < 40 && !bus.halted; i++) tick();
        chk("halt_reached", {31'd0, bus.halted}, 32'd1);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int L;
        int k;
        logic [15:0] w;

        bus.start = 0; bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0;
        bus.instr_ready = 0; bus.redirect = 0; bus.redirect_pc = '0;

        // Reset values
        #12;
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_pc", {24'd0, bus.pc}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_instr", {16'd0, bus.instr}, 32'd0);
        chk("rst_load_ack", {31'd0, bus.load_ack}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load + start in IDLE: write happens, start ignored
        load_word(8'h00, 16'h1012, 1'b1);
        chk("mem0_written", {16'd0, mem[0]}, 32'h1012);
        for (int i = 1; i < 256; i++) load_word(8'(i), 16'h1000 | 16'(i), 1'b0);
        load_word(8'h01, 16'h3220, 1'b0);
        load_word(8'h02, 16'h4230, 1'b0);
        load_word(8'h03, 16'hF000, 1'b0);
        chk("still_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("still_idle_halted", {31'd0, bus.halted}, 32'd0);

        // Straight-line program with decode always ready
        bus.instr_ready = 1'b1;
        do_start();
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        chk("t1_valid0", {31'd0, bus.instr_valid}, 32'd0);
        tick();
        chk("t1_w0", {16'd0, bus.instr}, 32'h1012);
        chk("t1_v0", {31'd0, bus.instr_valid}, 32'd1);
        chk("t1_pc1", {24'd0, bus.pc}, 32'd1);
        tick();
        chk("t1_w1", {16'd0, bus.instr}, 32'h3220);
        tick();
        chk("t1_w2", {16'd0, bus.instr}, 32'h4230);
        chk("t1_pc3", {24'd0, bus.pc}, 32'd3);
        tick();
        chk("t1_halted", {31'd0, bus.halted}, 32'd1);
        chk("t1_busy0", {31'd0, bus.busy}, 32'd0);
        chk("t1_pc_halt", {24'd0, bus.pc}, 32'd3);
        chk("t1_valid_clr", {31'd0, bus.instr_valid}, 32'd0);
        bus.redirect = 1'b1; bus.redirect_pc = 8'h40;
        tick();
        bus.redirect = 1'b0;
        chk("halt_redirect_ignored", {24'd0, bus.pc}, 32'd3);
        chk("halt_stays", {31'd0, bus.halted}, 32'd1);

        // Backpressure: first word held while decode stalls
        bus.instr_ready = 1'b0;
        do_start();
        tick();
        chk("t2_first", {16'd0, bus.instr}, 32'h1012);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_hold_instr", {16'd0, bus.instr}, 32'h1012);
            chk("t2_hold_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("t2_hold_pc", {24'd0, bus.pc}, 32'd1);
        end
        bus.instr_ready = 1'b1;
        tick();
        chk("t2_w1", {16'd0, bus.instr}, 32'h3220);
        chk("t2_pc2", {24'd0, bus.pc}, 32'd2);
        tick();
        chk("t2_w2", {16'd0, bus.instr}, 32'h4230);
        tick();
        chk("t2_halted", {31'd0, bus.halted}, 32'd1);
        chk("t2_valid_clr", {31'd0, bus.instr_valid}, 32'd0);
`ifdef FETCH_COUNT_EN
        chk("t2_count", {16'd0, instr_count}, 32'd3);
`endif

        // Redirect (also takes priority over a HALT word at the current pc)
        load_word(8'h03, 16'h1003, 1'b0);
        load_word(8'h05, 16'hF000, 1'b0);
        do_start();
        for (int i = 0; i < 5; i++) tick();
        chk("t3_pc5", {24'd0, bus.pc}, 32'd5);
        chk("t3_w4", {16'd0, bus.instr}, 32'h1004);
        bus.redirect = 1'b1; bus.redirect_pc = 8'h20;
        tick();
        bus.redirect = 1'b0;
        chk("t3_flush", {31'd0, bus.instr_valid}, 32'd0);
        chk("t3_pc20", {24'd0, bus.pc}, 32'h20);
        chk("t3_not_halted", {31'd0, bus.halted}, 32'd0);
        tick();
        chk("t3_target", {16'd0, bus.instr}, {16'd0, ref_mem[8'h20]});
        chk("t3_pc21", {24'd0, bus.pc}, 32'h21);

        // PC wrap FF -> 00
        bus.redirect = 1'b1; bus.redirect_pc = 8'hFE;
        tick();
        bus.redirect = 1'b0;
        chk("t4_pcFE", {24'd0, bus.pc}, 32'hFE);
        tick();
        chk("t4_wFE", {16'd0, bus.instr}, {16'd0, ref_mem[8'hFE]});
        tick();
        chk("t4_wFF", {16'd0, bus.instr}, {16'd0, ref_mem[8'hFF]});
        chk("t4_pc_wrap", {24'd0, bus.pc}, 32'd0);
        tick();
        chk("t4_w00", {16'd0, bus.instr}, {16'd0, ref_mem[8'h00]});
        run_to_halt();
        chk("t4_pc_halt", {24'd0, bus.pc}, 32'd5);

        // Load attempt while running is refused
        do_start();
        bus.load_en = 1'b1; bus.load_addr = 8'h80; bus.load_data = 16'hBEEF;
        #1;
        chk("t5_ack_run", {31'd0, bus.load_ack}, 32'd0);
        chk("t5_we_run", {31'd0, bus.mem_we}, 32'd0);
        chk("t5_addr_pc", {24'd0, bus.mem_addr}, {24'd0, bus.pc});
        tick();
        bus.load_en = 1'b0;
        chk("t5_unchanged", {16'd0, mem[8'h80]}, {16'd0, ref_mem[8'h80]});
        run_to_halt();
        load_word(8'h90, 16'h5A5A, 1'b1);
        chk("t5_still_halted", {31'd0, bus.halted}, 32'd1);
        chk("t5_written", {16'd0, mem[8'h90]}, 32'h5A5A);

        // Asynchronous reset between edges
        do_start();
        tick();
        tick();
        chk("t6_running", {31'd0, bus.instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("t6_pc", {24'd0, bus.pc}, 32'd0);
        chk("t6_busy", {31'd0, bus.busy}, 32'd0);
        chk("t6_halted", {31'd0, bus.halted}, 32'd0);
        chk("t6_instr", {16'd0, bus.instr}, 32'd0);
`ifdef FETCH_COUNT_EN
        chk("t6_count", {16'd0, instr_count}, 32'd0);
`endif
        chk("t6_mem_kept", {16'd0, mem[0]}, {16'd0, ref_mem[0]});
        tick();
        rst_n = 1'b1;

        // Random programs with random decode backpressure
        for (int it = 0; it < 20; it++) begin
            L = $urandom_range(1, 30);
            for (int i = 0; i < L; i++) begin
                w = 16'($urandom);
                w[15:12] = 4'($urandom_range(0, 14));
                load_word(8'(i), w, 1'b0);
            end
            w = 16'($urandom);
            w[15:12] = 4'hF;
            load_word(8'(L), w, 1'b0);
            bus.instr_ready = 1'b0;
            do_start();
            k = 0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                if (bus.halted && !bus.instr_valid) break;
                bus.instr_ready = 1'($urandom_range(0, 1));
                #1;
                if (bus.instr_valid && bus.instr_ready) begin
                    chk("rand_word", {16'd0, bus.instr}, {16'd0, ref_mem[k[7:0]]});
                    k++;
                end
                tick();
            end
            chk("rand_drained", {31'd0, bus.halted && !bus.instr_valid}, 32'd1);
            chk("rand_count", k, L);
            chk("rand_pc", {24'd0, bus.pc}, L);
`ifdef FETCH_COUNT_EN
            chk("rand_hw_count", {16'd0, instr_count}, L);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
